// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM states, one-hot rate codes
// and the gate-window target-count helper also used by the slow-clock generator.
package freq_meter_pkg;

  typedef enum logic {IDLE = 1'b0, GATE = 1'b1} state_t;

  localparam logic [3:0] RATE_NONE  = 4'b0000;
  localparam logic [3:0] RATE_1HZ   = 4'b0001;
  localparam logic [3:0] RATE_12HZ  = 4'b0010;
  localparam logic [3:0] RATE_48HZ  = 4'b0100;
  localparam logic [3:0] RATE_190HZ = 4'b1000;

  // Edges expected in one gate for a square wave of f_hz; 64-bit to survive f * GATE_CYCLES.
  function automatic int target_cnt(input int f_hz, input int gate_cycles, input int sys_clk);
    longint prod;
    prod = longint'(f_hz) * longint'(gate_cycles);
    return int'(prod / longint'(sys_clk));
  endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Brings an asynchronous input into clk with a 2-FF synchronizer plus a delay
// flop and emits a one-cycle pulse per rising edge (2-3 clk after the input rises).
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over back-to-back gate windows of GATE_CYCLES clocks and
// publishes each count, its saturation flag and its rate class through a valid/ack register.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int SYS_CLK     = 100000000,
  parameter int GATE_CYCLES = 100000000,
  parameter int CNT_W       = 16,
  parameter int TOL         = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  input  logic             meas_ack,
  output logic             meas_valid,
  output logic [CNT_W-1:0] freq,
  output logic [3:0]       rate,
  output logic             ovf,
  output logic             lost,
  output logic             busy
);

  localparam int     TMR_W   = $clog2(GATE_CYCLES);
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
  localparam int     T1      = target_cnt(1,   GATE_CYCLES, SYS_CLK);
  localparam int     T12     = target_cnt(12,  GATE_CYCLES, SYS_CLK);
  localparam int     T48     = target_cnt(48,  GATE_CYCLES, SYS_CLK);
  localparam int     T190    = target_cnt(190, GATE_CYCLES, SYS_CLK);

  if (GATE_CYCLES < 2 ||
      longint'(T1)   + TOL > CNT_MAX || longint'(T12)  + TOL > CNT_MAX ||
      longint'(T48)  + TOL > CNT_MAX || longint'(T190) + TOL > CNT_MAX) begin : g_bad_param
    $error("freq_meter: GATE_CYCLES below 2 or a rate target does not fit in CNT_W");
  end

  // Lower bound clamps at zero so small targets never wrap.
  function automatic logic in_band(input logic [CNT_W-1:0] cnt, input int tgt);
    longint lo;
    lo = (tgt > TOL) ? longint'(tgt - TOL) : 64'sd0;
    return (longint'(cnt) >= lo) && (longint'(cnt) <= longint'(tgt) + TOL);
  endfunction

  function automatic logic [3:0] classify(input logic [CNT_W-1:0] cnt, input logic sat);
    if (sat)                return RATE_NONE;
    if (in_band(cnt, T1))   return RATE_1HZ;
    if (in_band(cnt, T12))  return RATE_12HZ;
    if (in_band(cnt, T48))  return RATE_48HZ;
    if (in_band(cnt, T190)) return RATE_190HZ;
    return RATE_NONE;
  endfunction

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] edge_cnt;
  logic             gate_ovf;
  logic             rise;

  edge_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise)
  );

  logic             cnt_full;
  logic             last_cycle;
  logic             publish;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  assign cnt_full   = &edge_cnt;
  assign cnt_next   = cnt_full ? edge_cnt : edge_cnt + CNT_W'(rise);
  assign ovf_next   = gate_ovf | (cnt_full & rise);
  assign last_cycle = (timer == TMR_W'(GATE_CYCLES - 1));
  assign publish    = (state == GATE) && en && last_cycle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      edge_cnt <= '0;
      gate_ovf <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state    <= GATE;
            busy     <= 1'b1;
            timer    <= '0;
            edge_cnt <= '0;
            gate_ovf <= 1'b0;
          end
        end
        GATE: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (last_cycle) begin
            // Next gate starts on the following cycle with no gap.
            timer    <= '0;
            edge_cnt <= '0;
            gate_ovf <= 1'b0;
          end else begin
            timer    <= timer + TMR_W'(1);
            edge_cnt <= cnt_next;
            gate_ovf <= ovf_next;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid <= 1'b0;
      freq       <= '0;
      rate       <= RATE_NONE;
      ovf        <= 1'b0;
      lost       <= 1'b0;
    end else if (publish) begin
      meas_valid <= 1'b1;
      freq       <= cnt_next;
      ovf        <= ovf_next;
      rate       <= classify(cnt_next, ovf_next);
      // An ack in the publish cycle consumed the old result, so nothing is lost.
      if (meas_valid && !meas_ack)
        lost <= 1'b1;
    end else if (meas_ack) begin
      meas_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a 2400-cycle gate (SYS_CLK = GATE_CYCLES, so target = Hz);
// sig_in comes from a phase accumulator giving exactly f rising edges per gate.
module tb_freq_meter;
  import freq_meter_pkg::*;

  localparam int G = 2400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sig_in = 1'b0;
  logic        meas_ack = 1'b0;
  logic        meas_valid, ovf, lost, busy;
  logic [15:0] freq;
  logic [3:0]  rate;

  logic        en8 = 1'b0;
  logic        sig8 = 1'b0;
  logic        meas_valid8, ovf8, lost8, busy8;
  logic [7:0]  freq8;
  logic [3:0]  rate8;

  int checks = 0;
  int errors = 0;
  int nco_f = 0;
  int acc = 0;
  bit nco_clr = 1'b0;

  always #5 clk = ~clk;

  freq_meter #(.SYS_CLK(G), .GATE_CYCLES(G), .CNT_W(16), .TOL(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .meas_ack(meas_ack),
    .meas_valid(meas_valid), .freq(freq), .rate(rate), .ovf(ovf), .lost(lost), .busy(busy)
  );

  freq_meter #(.SYS_CLK(G), .GATE_CYCLES(G), .CNT_W(8), .TOL(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .sig_in(sig8), .meas_ack(1'b0),
    .meas_valid(meas_valid8), .freq(freq8), .rate(rate8), .ovf(ovf8), .lost(lost8), .busy(busy8)
  );

  // 2*f toggles per G clocks: any G-cycle window holds exactly f rising edges.
  initial forever begin
    @(negedge clk);
    sig8 = ~sig8;
    if (nco_clr) begin
      acc     = 0;
      sig_in  = 1'b0;
      nco_clr = 1'b0;
    end else begin
      acc = acc + 2 * nco_f;
      if (acc >= G) begin
        acc    = acc - G;
        sig_in = ~sig_in;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    while (!meas_valid && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(meas_valid), 32'd1);
  endtask

  task automatic restart(input int f);
    en       = 1'b0;
    meas_ack = 1'b1;
    tick();
    meas_ack = 1'b0;
    nco_f    = f;
    nco_clr  = 1'b1;
    tick(10);
  endtask

  task automatic measure(input int f, input logic [3:0] exp_rate);
    int n;
    restart(f);
    en = 1'b1;
    wait_valid($sformatf("sweep%0d", f), 2600, n);
    chk($sformatf("sweep%0d_freq", f), 32'(freq), 32'(f));
    chk($sformatf("sweep%0d_rate", f), 32'(rate), 32'(exp_rate));
    chk($sformatf("sweep%0d_ovf", f), 32'(ovf), 32'd0);
  endtask

  typedef struct {int f; logic [3:0] r;} vec_t;
  vec_t sweep[8];

  initial begin
    int n;
    sweep[0] = '{1,   4'b0001};
    sweep[1] = '{48,  4'b0100};
    sweep[2] = '{190, 4'b1000};
    sweep[3] = '{24,  4'b0000};
    sweep[4] = '{13,  4'b0010};
    sweep[5] = '{14,  4'b0000};
    sweep[6] = '{189, 4'b1000};
    sweep[7] = '{2,   4'b0001};

    // Reset state
    tick(3);
    chk("rst_freq", 32'(freq), 32'd0);
    chk("rst_rate", 32'(rate), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_lost", 32'(lost), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid8", 32'(meas_valid8), 32'd0);
    rst_n = 1'b1;

    // 12 Hz first gate, plus saturating 8-bit instance in parallel
    nco_f   = 12;
    nco_clr = 1'b1;
    tick(10);
    en  = 1'b1;
    en8 = 1'b1;
    tick();
    chk("t1_busy", 32'(busy), 32'd1);
    wait_valid("t1", 2600, n);
    chk("t1_latency", 32'(n + 1), 32'd2401);
    chk("t1_freq", 32'(freq), 32'd12);
    chk("t1_rate", 32'(rate), 32'b0010);
    chk("t1_ovf", 32'(ovf), 32'd0);
    chk("t1_lost", 32'(lost), 32'd0);
    chk("t4_valid8", 32'(meas_valid8), 32'd1);
    chk("t4_freq8", 32'(freq8), 32'd255);
    chk("t4_ovf8", 32'(ovf8), 32'd1);
    chk("t4_rate8", 32'(rate8), 32'd0);
    en8 = 1'b0;

    // Ack lands on the next publish cycle: new result, valid held, no loss
    tick(2399);
    chk("t1_hold_valid", 32'(meas_valid), 32'd1);
    meas_ack = 1'b1;
    tick();
    meas_ack = 1'b0;
    chk("t1_ackpub_valid", 32'(meas_valid), 32'd1);
    chk("t1_ackpub_lost", 32'(lost), 32'd0);
    chk("t1_ackpub_freq", 32'(freq), 32'd12);
    meas_ack = 1'b1;
    tick();
    meas_ack = 1'b0;
    chk("t1_ack_clear", 32'(meas_valid), 32'd0);

    // Frequency sweep incl. tolerance boundaries
    foreach (sweep[i]) measure(sweep[i].f, sweep[i].r);

    // en dropped mid-gate discards the count; re-enable measures a fresh gate
    restart(48);
    en = 1'b1;
    tick(1001);
    chk("t5_busy_gate", 32'(busy), 32'd1);
    en = 1'b0;
    tick();
    chk("t5_busy_drop", 32'(busy), 32'd0);
    tick(2500);
    chk("t5_no_valid", 32'(meas_valid), 32'd0);
    en = 1'b1;
    wait_valid("t5", 2600, n);
    chk("t5_latency", 32'(n), 32'd2401);
    chk("t5_freq", 32'(freq), 32'd48);

    // Unacknowledged results: overwrite sets lost
    restart(0);
    en = 1'b1;
    wait_valid("t3", 2600, n);
    chk("t3_freq0", 32'(freq), 32'd0);
    chk("t3_rate0", 32'(rate), 32'b0001);
    chk("t3_lost0", 32'(lost), 32'd0);
    nco_f   = 12;
    nco_clr = 1'b1;
    tick(2400);
    chk("t3_valid2", 32'(meas_valid), 32'd1);
    chk("t3_lost2", 32'(lost), 32'd1);
    chk("t3_freq2", 32'(freq), 32'd12);
    tick(2399);
    meas_ack = 1'b1;
    tick();
    meas_ack = 1'b0;
    chk("t3_valid3", 32'(meas_valid), 32'd1);
    chk("t3_lost3", 32'(lost), 32'd1);
    chk("t3_freq3", 32'(freq), 32'd12);

    // Asynchronous reset mid-gate, then a clean gate
    tick(500);
    rst_n   = 1'b0;
    nco_clr = 1'b1;
    #1;
    chk("t6_freq", 32'(freq), 32'd0);
    chk("t6_rate", 32'(rate), 32'd0);
    chk("t6_valid", 32'(meas_valid), 32'd0);
    chk("t6_lost", 32'(lost), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ovf", 32'(ovf), 32'd0);
    tick(3);
    rst_n = 1'b1;
    wait_valid("t6", 2600, n);
    chk("t6_clean_freq", 32'(freq), 32'd12);
    chk("t6_clean_lost", 32'(lost), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
